instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  request fields valid.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 fmt  in  2  instruction format: 00 two-op, 01 one-op, 10 jump, 11 illegal.
REQ-007 opcode  in  4  two-op IW[15:12]; one-op and jump use opcode[2:0].
REQ-008 src_reg, dst_reg  in  4 each  register numbers.
REQ-009 as_mode  in  2  source (one-op: operand) addressing mode.
REQ-010 ad_mode  in  1  destination addressing mode.
REQ-011 bw  in  1  byte/word select.
REQ-012 jmp_off  in  10  signed word offset.
REQ-013 src_ext, dst_ext  in  16 each  extension word values.
REQ-014 word_out  out  16  emitted word.
REQ-015 word_valid  out  1  word_out valid.
REQ-016 word_ready  in  1  consumer accepts word.
REQ-017 word_last  out  1  word_out is the final word of the instruction.
REQ-018 err  out  1  one-cycle pulse on an illegal request.

Function
REQ-019 The FSM SHALL have states IDLE, EMIT_IW, EMIT_SRC and EMIT_DST; req_ready SHALL be 1 only in IDLE.
REQ-020 Accept occurs when req_valid and req_ready are both 1; all inputs SHALL be registered at accept, and input changes afterwards SHALL have no effect.
REQ-021 Two-op encoding SHALL be IW = {opcode, src_reg, ad_mode, bw, as_mode, dst_reg}.
- opcode < 4 is illegal.
REQ-022 One-op encoding SHALL be IW = {6'b000100, opcode[2:0], bw, as_mode, dst_reg}.
- opcode[2:0] = 7 is illegal.
- bw forced to 0 for opcodes 1 (SWPB), 3 (SXT), 5 (CALL) and 6 (RETI).
- RETI (opcode 6) additionally forces as_mode = 00 and dst_reg = 0.
REQ-023 Jump encoding SHALL be IW = {3'b001, opcode[2:0], jmp_off}.
REQ-024 A source extension word (src_ext) SHALL follow IW in either of these cases:
- as_mode = 01 and the operand register is not R3;
- as_mode = 11 and the operand register is R0 (immediate).
- Operand register is src_reg for two-op and dst_reg for one-op.
- R3 with any mode, and R2 with modes 10/11, are constant generators and produce no source extension word.
REQ-025 A destination extension word (dst_ext) SHALL follow only for two-op with ad_mode = 1.
- Jump and RETI emit no extension words.
REQ-026 Emission order SHALL be IW, then source extension, then destination extension, skipping absent words.
- word_last = 1 exactly on the final word.
REQ-027 word_valid SHALL assert the cycle after accept.
- Each word is held stable while word_valid = 1 and word_ready = 0.
- The FSM advances on word_valid & word_ready.
- word_valid is never deasserted before its handshake completes.
REQ-028 After the last word's handshake, the FSM SHALL return to IDLE with req_ready = 1 the next cycle, so throughput is one instruction per (words + 1) cycles.
REQ-029 An illegal request (fmt = 11, or as in REQ-021/REQ-022) SHALL:
- be accepted;
- pulse err for exactly the one cycle after accept;
- emit no words, with word_valid = 0;
- return to IDLE in that same cycle.
REQ-030 When word_valid = 0, word_out and word_last SHALL be 0.

Reset
REQ-031 While rst_n = 0, the following SHALL hold immediately (asynchronously), independent of clk:
- state = IDLE;
- req_ready = 1;
- word_valid = 0, word_last = 0, word_out = 16'h0000, err = 0.
REQ-032 Reset asserted mid-emission SHALL abort the instruction; no remaining words are emitted after rst_n deasserts.

Verification
REQ-033 fmt=00, opcode=4, src_reg=4, as_mode=00, ad_mode=0, bw=0, dst_reg=5 -> single word 0x4405 with word_last=1; req_ready=1 two cycles after accept.
REQ-034 fmt=00, opcode=5, src_reg=0, as_mode=11, ad_mode=1, dst_reg=2, src_ext=0x1234, dst_ext=0x0200 -> words 0x50B2, 0x1234, 0x0200; word_last only on 0x0200.
REQ-035 REQ-034 with word_ready held 0 for 3 cycles while 0x1234 is presented -> word_out stays 0x1234 with word_valid=1 throughout; no word is skipped or duplicated.
REQ-036 fmt=10, opcode=7, jmp_off=0x3FF -> 0x3FFF, last=1; fmt=01, opcode=6, as_mode=11, dst_reg=7, bw=1 -> 0x1300 only.
REQ-037 fmt=00, opcode=2 -> err high exactly one cycle and no word_valid; fmt=00, opcode=4, src_reg=3, as_mode=11 -> single word, no extension.
REQ-038 rst_n pulsed low during the second word of REQ-034 -> word_valid=0 immediately, no further words, and the next request encodes correctly.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction word encoder: turns one accepted request into an instruction word
// plus optional source/destination extension words over a valid/ready stream.
`timescale 1ns/1ps
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  fmt,
  input  logic [3:0]  opcode,
  input  logic [3:0]  src_reg,
  input  logic [3:0]  dst_reg,
  input  logic [1:0]  as_mode,
  input  logic        ad_mode,
  input  logic        bw,
  input  logic [9:0]  jmp_off,
  input  logic [15:0] src_ext,
  input  logic [15:0] dst_ext,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, EMIT_IW, EMIT_SRC, EMIT_DST} state_e;

  state_e      state_q, state_d;
  logic [15:0] iw_q, src_q, dst_q;
  logic        has_src_q, has_dst_q, err_q;

  logic [15:0] iw_d;
  logic        has_src_d, has_dst_d, illegal;
  logic [3:0]  op_reg, dst_eff;
  logic [1:0]  op_mode, as_eff;
  logic        bw_eff;
  logic        accept, hs;

  assign accept = req_valid & req_ready;
  assign hs     = word_valid & word_ready;

  // Decode straight from the request inputs; the result is captured only at accept.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    iw_d      = '0;
    has_dst_d = 1'b0;
    illegal   = 1'b0;
    op_reg    = '0;
    op_mode   = '0;
    bw_eff    = bw;
    as_eff    = as_mode;
    dst_eff   = dst_reg;
    unique case (fmt)
      2'b00: begin
        illegal   = (opcode < 4'd4);
        iw_d      = {opcode, src_reg, ad_mode, bw, as_mode, dst_reg};
        op_reg    = src_reg;
        op_mode   = as_mode;
        has_dst_d = ad_mode;
      end
      2'b01: begin
        illegal = (opcode[2:0] == 3'd7);
        if (opcode[2:0] == 3'd1 || opcode[2:0] == 3'd3 ||
            opcode[2:0] == 3'd5 || opcode[2:0] == 3'd6) bw_eff = 1'b0;
        if (opcode[2:0] == 3'd6) begin
          as_eff  = 2'b00;
          dst_eff = 4'd0;
        end
        iw_d    = {6'b000100, opcode[2:0], bw_eff, as_eff, dst_eff};
        op_reg  = dst_eff;
        op_mode = as_eff;
      end
      2'b10:   iw_d = {3'b001, opcode[2:0], jmp_off};
      default: illegal = 1'b1;
    endcase
    // R3 (any mode) and R2 (modes 10/11) are constant generators without an extension word.
    has_src_d = !fmt[1] &&
                ((op_mode == 2'b01 && op_reg != 4'd3) ||
                 (op_mode == 2'b11 && op_reg == 4'd0));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept && !illegal) state_d = EMIT_IW;
      EMIT_IW:  if (hs) state_d = has_src_q ? EMIT_SRC : (has_dst_q ? EMIT_DST : IDLE);
      EMIT_SRC: if (hs) state_d = has_dst_q ? EMIT_DST : IDLE;
      EMIT_DST: if (hs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      iw_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      has_src_q <= 1'b0;
      has_dst_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept & illegal;
      if (accept) begin
        iw_q      <= iw_d;
        src_q     <= src_ext;
        dst_q     <= dst_ext;
        has_src_q <= has_src_d;
        has_dst_q <= has_dst_d;
      end
    end
  end

  // Outputs decode from registered state only, so reset clears them asynchronously.
  always_comb begin
    req_ready  = (state_q == IDLE);
    word_valid = (state_q != IDLE);
    word_out   = '0;
    word_last  = 1'b0;
    unique case (state_q)
      EMIT_IW: begin
        word_out  = iw_q;
        word_last = !has_src_q && !has_dst_q;
      end
      EMIT_SRC: begin
        word_out  = src_q;
        word_last = !has_dst_q;
      end
      EMIT_DST: begin
        word_out  = dst_q;
        word_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized requests
// compared against an arithmetic reference model of the encoding rules.
`timescale 1ns/1ps
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  fmt;
  logic [3:0]  opcode, src_reg, dst_reg;
  logic [1:0]  as_mode;
  logic        ad_mode, bw;
  logic [9:0]  jmp_off;
  logic [15:0] src_ext, dst_ext;
  logic [15:0] word_out;
  logic        word_valid, word_ready, word_last, err;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .fmt(fmt), .opcode(opcode), .src_reg(src_reg), .dst_reg(dst_reg),
    .as_mode(as_mode), .ad_mode(ad_mode), .bw(bw), .jmp_off(jmp_off),
    .src_ext(src_ext), .dst_ext(dst_ext), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last), .err(err)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [3:0]  opcode, src_reg, dst_reg;
    logic [1:0]  as_mode;
    logic        ad_mode, bw;
    logic [9:0]  jmp_off;
    logic [15:0] src_ext, dst_ext;
  } req_t;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  bit          exp_err;

  // Reference model: field weights as plain arithmetic on the encoding rules.
  function automatic void build_expected(input req_t r);
    int iw, op, areg, amode, bwe;
    bit ext_dst;
    exp_q.delete();
    exp_err = 0;
    ext_dst = 0;
    op      = int'(r.opcode) % 8;
    areg    = -1;
    amode   = 0;
    iw      = 0;
    case (r.fmt)
      2'd0: begin
        if (int'(r.opcode) < 4) exp_err = 1;
        iw = int'(r.opcode) * 4096 + int'(r.src_reg) * 256 + int'(r.ad_mode) * 128 +
             int'(r.bw) * 64 + int'(r.as_mode) * 16 + int'(r.dst_reg);
        areg    = int'(r.src_reg);
        amode   = int'(r.as_mode);
        ext_dst = r.ad_mode;
      end
      2'd1: begin
        if (op == 7) exp_err = 1;
        bwe   = (op inside {1, 3, 5, 6}) ? 0 : int'(r.bw);
        areg  = int'(r.dst_reg);
        amode = int'(r.as_mode);
        if (op == 6) begin
          areg  = 0;
          amode = 0;
        end
        iw = 'h1000 + op * 128 + bwe * 64 + amode * 16 + areg;
      end
      2'd2: iw = 'h2000 + op * 1024 + int'(r.jmp_off);
      default: exp_err = 1;
    endcase
    if (exp_err) return;
    exp_q.push_back(iw[15:0]);
    if ((amode == 1 && areg != 3) || (amode == 3 && areg == 0)) exp_q.push_back(r.src_ext);
    if (ext_dst) exp_q.push_back(r.dst_ext);
  endfunction

  function automatic req_t zero_req();
    req_t r;
    r.fmt = '0; r.opcode = '0; r.src_reg = '0; r.dst_reg = '0; r.as_mode = '0;
    r.ad_mode = 1'b0; r.bw = 1'b0; r.jmp_off = '0; r.src_ext = '0; r.dst_ext = '0;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.fmt = 2'($urandom); r.opcode = 4'($urandom); r.src_reg = 4'($urandom);
    r.dst_reg = 4'($urandom); r.as_mode = 2'($urandom); r.ad_mode = 1'($urandom);
    r.bw = 1'($urandom); r.jmp_off = 10'($urandom); r.src_ext = 16'($urandom);
    r.dst_ext = 16'($urandom);
    return r;
  endfunction

  task automatic apply(input req_t r);
    fmt = r.fmt; opcode = r.opcode; src_reg = r.src_reg; dst_reg = r.dst_reg;
    as_mode = r.as_mode; ad_mode = r.ad_mode; bw = r.bw; jmp_off = r.jmp_off;
    src_ext = r.src_ext; dst_ext = r.dst_ext;
  endtask

  // Present a request at a negedge, accept at the posedge, scramble inputs afterwards.
  task automatic send(input string name, input req_t r);
    @(negedge clk);
    check($sformatf("%s.req_ready_idle", name), req_ready, 1);
    apply(r);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    apply(rand_req());
    req_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: hold ready low 3 cycles on word 1
  task automatic run_instr(input string name, input req_t r, input int mode);
    int  idx, stall, budget;
    logic rdy;
    idx = 0; stall = 0; budget = 0;
    build_expected(r);
    send(name, r);
    if (exp_err) begin
      @(negedge clk);
      check($sformatf("%s.err_pulse", name), err, 1);
      check($sformatf("%s.err_no_valid", name), word_valid, 0);
      check($sformatf("%s.err_ready", name), req_ready, 1);
      @(negedge clk);
      check($sformatf("%s.err_clear", name), err, 0);
      check($sformatf("%s.err_no_valid2", name), word_valid, 0);
      return;
    end
    while (idx < exp_q.size() && budget < 80) begin
      @(negedge clk);
      budget++;
      check($sformatf("%s.valid[%0d]", name, idx), word_valid, 1);
      check($sformatf("%s.word[%0d]", name, idx), word_out, exp_q[idx]);
      check($sformatf("%s.last[%0d]", name, idx), word_last, (idx == exp_q.size() - 1));
      check($sformatf("%s.err_low[%0d]", name, idx), err, 0);
      check($sformatf("%s.busy[%0d]", name, idx), req_ready, 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom);
        default: begin
          rdy = !(idx == 1 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      word_ready = rdy;
      if (rdy) idx++;
    end
    check($sformatf("%s.words_done", name), idx, exp_q.size());
    @(negedge clk);
    word_ready = 1'b0;
    check($sformatf("%s.back_idle", name), req_ready, 1);
    check($sformatf("%s.idle_valid", name), word_valid, 0);
    check($sformatf("%s.idle_word", name), word_out, 0);
    check($sformatf("%s.idle_last", name), word_last, 0);
  endtask

  req_t r, r34;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; word_ready = 1'b0;
    apply(zero_req());
    #1;
    check("rst.req_ready", req_ready, 1);
    check("rst.word_valid", word_valid, 0);
    check("rst.word_out", word_out, 0);
    check("rst.word_last", word_last, 0);
    check("rst.err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    r = zero_req(); r.opcode = 4; r.src_reg = 4; r.dst_reg = 5;
    run_instr("mov_reg", r, 0);

    r34 = zero_req(); r34.opcode = 5; r34.as_mode = 2'b11; r34.ad_mode = 1'b1;
    r34.dst_reg = 2; r34.src_ext = 16'h1234; r34.dst_ext = 16'h0200;
    run_instr("imm_abs", r34, 1);
    run_instr("imm_abs_stall", r34, 2);

    r = zero_req(); r.fmt = 2'b10; r.opcode = 7; r.jmp_off = 10'h3FF;
    run_instr("jmp", r, 0);
    r = zero_req(); r.fmt = 2'b01; r.opcode = 6; r.as_mode = 2'b11; r.dst_reg = 7; r.bw = 1'b1;
    run_instr("reti", r, 1);

    r = zero_req(); r.opcode = 2;
    run_instr("ill_two_op", r, 0);
    r = zero_req(); r.opcode = 4; r.src_reg = 3; r.as_mode = 2'b11; r.dst_reg = 5;
    run_instr("cg_r3", r, 0);
    r = zero_req(); r.fmt = 2'b01; r.opcode = 7;
    run_instr("ill_one_op", r, 0);
    r = zero_req(); r.fmt = 2'b11; r.opcode = 9;
    run_instr("ill_fmt", r, 0);
    r = zero_req(); r.fmt = 2'b01; r.opcode = 4; r.as_mode = 2'b01; r.dst_reg = 2;
    r.src_ext = 16'hBEEF; r.bw = 1'b1;
    run_instr("push_abs", r, 1);

    // Reset in the middle of the second word of the three-word instruction.
    build_expected(r34);
    send("rst_mid", r34);
    @(negedge clk);
    check("rst_mid.word0", word_out, 16'h50B2);
    word_ready = 1'b1;
    @(negedge clk);
    check("rst_mid.word1", word_out, 16'h1234);
    word_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid.valid", word_valid, 0);
    check("rst_mid.ready", req_ready, 1);
    check("rst_mid.word_out", word_out, 0);
    check("rst_mid.last", word_last, 0);
    check("rst_mid.err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid.quiet[%0d]", i), word_valid, 0);
    end
    word_ready = 1'b0;
    run_instr("after_rst", r34, 0);

    for (int i = 0; i < 300; i++) begin
      r = rand_req();
      run_instr($sformatf("rnd%0d", i), r, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
